// File: rtl/usr_pkg.sv
// Shared types and constants for the serial receive path.
// Direction encodings match the transmit-side shift register.
package usr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_rx_shifter.sv
// Bidirectional assembly register. q_next exposes the value the register takes
// at the next edge so the owner can capture a completed word in the same cycle.
module usr_rx_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] base;

  // Clear and shift may coincide: the first bit of a new frame lands on a clean register.
  always_comb begin
    base   = clear ? '0 : sreg_q;
    sreg_d = base;
    if (shift_en) begin
      if (dir == DIR_LSB_FIRST) sreg_d = {serial_in, base[WIDTH-1:1]};
      else                      sreg_d = {base[WIDTH-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sreg_q <= '0;
    else        sreg_q <= sreg_d;
  end

  assign q_next = sreg_d;

endmodule

// File: rtl/usr_serial_receiver.sv
// Serial-to-parallel receiver: frames bit strobes into WIDTH-bit words and
// presents them on a one-entry output buffer with a sticky overrun flag.
module usr_serial_receiver
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             dir,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  input  logic             clear_overrun,
  output state_e           state_dbg
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             shift_en;
  logic             sh_clear;
  logic             sh_dir;
  logic             complete;
  logic             pop;
  logic [WIDTH-1:0] sh_next;

  usr_rx_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clear     (sh_clear),
    .shift_en  (shift_en),
    .dir       (sh_dir),
    .serial_in (serial_in),
    .q_next    (sh_next)
  );

  // Output handshake: a word moves on any edge where data_valid & data_ready;
  // data_out is held stable while data_valid is high and not yet accepted.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    shift_en = 1'b0;
    sh_clear = 1'b0;
    sh_dir   = dir_q;
    complete = 1'b0;
    pop      = valid_q & data_ready;

    if (frame_start) begin
      state_d  = ST_SHIFT;
      dir_d    = dir;
      sh_dir   = dir;
      sh_clear = 1'b1;
      shift_en = bit_valid;
      cnt_d    = bit_valid ? CNT_W'(1) : '0;
    end else if (state_q == ST_SHIFT && bit_valid) begin
      shift_en = 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (pop)           valid_d = 1'b0;
    if (clear_overrun) ovr_d   = 1'b0;

    // A completed word only enters the buffer if the slot is free this edge.
    if (complete) begin
      if (!valid_q || pop) begin
        data_d  = sh_next;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_MSB_FIRST;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == ST_SHIFT);
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_usr_serial_receiver.sv
// Bench for usr_serial_receiver: directed scenarios with literal expectations,
// then randomized strobes checked every cycle against a frame-level model.
module tb_usr_serial_receiver;
  import usr_pkg::*;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          serial_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          dir = 1'b0;
  logic          data_ready = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          busy;
  logic [CW-1:0] bit_count;
  logic          overrun;
  state_e        state_dbg;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  usr_serial_receiver #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .bit_valid     (bit_valid),
    .frame_start   (frame_start),
    .dir           (dir),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .busy          (busy),
    .bit_count     (bit_count),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .state_dbg     (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic         bits_q[$];      // bits of the frame in progress, in arrival order
  logic [W-1:0] exp_q[$];       // the one-entry output buffer (size 0 or 1)
  logic [W-1:0] m_last;         // last word shown on data_out
  bit           m_in_frame;
  logic         m_dir;
  bit           m_ovr;

  function automatic logic [W-1:0] assemble(input logic d);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (d) w[i] = bits_q[i];
      else   w[W-1-i] = bits_q[i];
    end
    return w;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits_q.delete();
      exp_q.delete();
      m_last     = '0;
      m_in_frame = 0;
      m_dir      = 1'b0;
      m_ovr      = 0;
    end else begin
      bit           done;
      bit           took;
      logic [W-1:0] word;
      done = 0;
      word = '0;
      took = (exp_q.size() != 0) && data_ready;
      if (frame_start) begin
        m_in_frame = 1;
        m_dir      = dir;
        bits_q.delete();
        if (bit_valid) bits_q.push_back(serial_in);
      end else if (m_in_frame && bit_valid) begin
        bits_q.push_back(serial_in);
        if (bits_q.size() == W) begin
          word = assemble(m_dir);
          done = 1;
          bits_q.delete();
          m_in_frame = 0;
        end
      end
      if (took) void'(exp_q.pop_front());
      if (clear_overrun) m_ovr = 0;
      if (done) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(word);
          m_last = word;
        end else begin
          m_ovr = 1;
        end
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_data_valid", 32'(data_valid), 32'(exp_q.size() != 0));
      chk("cmp_data_out",   32'(data_out),   32'(m_last));
      chk("cmp_busy",       32'(busy),       32'(m_in_frame));
      chk("cmp_state",      32'(state_dbg == ST_SHIFT), 32'(m_in_frame));
      chk("cmp_bit_count",  32'(bit_count),  32'(bits_q.size()));
      chk("cmp_overrun",    32'(overrun),    32'(m_ovr));
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge; the task returns at the same point
  // one cycle later, so DUT outputs read afterwards reflect the edge just taken.
  task automatic cyc(input logic fs, input logic bv, input logic si, input logic d);
    frame_start = fs;
    bit_valid   = bv;
    serial_in   = si;
    dir         = d;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [W-1:0] w, input logic d, input logic rdy_last);
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) data_ready = rdy_last;
      cyc(i == 0, 1'b1, d ? w[i] : w[W-1-i], d);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset held while strobes are driven
    @(negedge clk);
    #1;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_data_out", 32'(data_out), 0);
      chk("rst_valid",    32'(data_valid), 0);
      chk("rst_busy",     32'(busy), 0);
      chk("rst_overrun",  32'(overrun), 0);
    end
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    reset       = 1'b1;
    idle(1);
    chk("post_rst_valid", 32'(data_valid), 0);
    chk("post_rst_count", 32'(bit_count), 0);

    // MSB first, consecutive bits
    data_ready = 1'b0;
    send(4'b1010, DIR_MSB_FIRST, 1'b0);
    chk("msb_valid", 32'(data_valid), 1);
    chk("msb_data",  32'(data_out), 32'h a);
    chk("msb_busy",  32'(busy), 0);
    data_ready = 1'b1;
    idle(1);
    chk("msb_popped", 32'(data_valid), 0);
    data_ready = 1'b0;

    // LSB first with 2-cycle gaps
    cyc(1'b1, 1'b1, 1'b1, DIR_LSB_FIRST);
    chk("lsb_cnt1", 32'(bit_count), 1);
    idle(2);
    cyc(1'b0, 1'b1, 1'b1, DIR_MSB_FIRST);
    chk("lsb_cnt2", 32'(bit_count), 2);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0, DIR_MSB_FIRST);
    chk("lsb_cnt3", 32'(bit_count), 3);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0, DIR_MSB_FIRST);
    chk("lsb_cnt0", 32'(bit_count), 0);
    chk("lsb_data", 32'(data_out), 32'h3);
    chk("lsb_valid", 32'(data_valid), 1);
    data_ready = 1'b1;
    idle(1);
    data_ready = 1'b0;

    // abort after two bits, restart with 0110
    cyc(1'b1, 1'b1, 1'b1, DIR_MSB_FIRST);
    cyc(1'b0, 1'b1, 1'b1, DIR_MSB_FIRST);
    chk("abort_cnt", 32'(bit_count), 2);
    send(4'b0110, DIR_MSB_FIRST, 1'b0);
    chk("abort_data",  32'(data_out), 32'h6);
    chk("abort_valid", 32'(data_valid), 1);
    data_ready = 1'b1;
    idle(1);
    chk("abort_one_word", 32'(data_valid), 0);
    data_ready = 1'b0;

    // backpressure: second word dropped
    send(4'b1010, DIR_MSB_FIRST, 1'b0);
    send(4'b1100, DIR_MSB_FIRST, 1'b0);
    chk("bp_data",    32'(data_out), 32'h a);
    chk("bp_overrun", 32'(overrun), 1);
    data_ready    = 1'b1;
    clear_overrun = 1'b1;
    idle(1);
    chk("bp_drained", 32'(data_valid), 0);
    chk("bp_cleared", 32'(overrun), 0);
    clear_overrun = 1'b0;
    data_ready    = 1'b0;

    // consume on the same edge the next word completes
    send(4'b1010, DIR_MSB_FIRST, 1'b0);
    send(4'b1100, DIR_MSB_FIRST, 1'b1);
    chk("sim_data",    32'(data_out), 32'h c);
    chk("sim_valid",   32'(data_valid), 1);
    chk("sim_overrun", 32'(overrun), 0);
    idle(1);
    data_ready = 1'b0;

    // randomized traffic, occasional mid-frame reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
      end
      data_ready    = ($urandom_range(0, 1) == 1);
      clear_overrun = ($urandom_range(0, 9) == 0);
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usr_serial_receiver.md
Name: usr_serial_receiver

Overview:
Receive-side counterpart of the universal shift register's serial output. Accepts a bit-serial stream (one bit per qualified strobe), framed by a start pulse. Reassembles each frame into a WIDTH-bit parallel word, in either MSB-first (left-shift) or LSB-first (right-shift) order. Presents each word on a one-entry valid/ready output buffer. Sits between a serializing shift register and any parallel consumer.

Parameters:
WIDTH, 4, word width in bits (>=2)
CNT_W, $clog2(WIDTH+1), width of bit counter

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
serial_in  input  1  serial data bit, sampled only when bit_valid=1
bit_valid  input  1  qualifies serial_in for this cycle
frame_start  input  1  marks first bit of a new frame; may coincide with bit_valid
dir  input  1  0 = MSB first (shift-left assembly), 1 = LSB first (shift-right assembly); sampled at frame_start, held for the frame
data_out  output  WIDTH  assembled word; stable while data_valid=1
data_valid  output  1  output buffer holds an unconsumed word
data_ready  input  1  consumer accepts word when data_valid & data_ready
busy  output  1  frame in progress (state SHIFT)
bit_count  output  CNT_W  bits captured in current frame
overrun  output  1  sticky: a completed word was dropped
clear_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (reset=0, async): state=IDLE, shift reg=0, data_out=0, data_valid=0, busy=0, bit_count=0, overrun=0, latched dir=0.
- States: IDLE, SHIFT. busy=1 iff SHIFT.
- IDLE: frame_start=1 -> latch dir, go SHIFT. If bit_valid=1 in the same cycle, capture that bit (bit_count=1). Otherwise bit_count=0. bit_valid without frame_start is ignored.
- SHIFT: each bit_valid=1 captures one bit.
  - dir=0: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - dir=1: sreg <= {serial_in, sreg[WIDTH-1:1]}.
  - bit_count increments on each capture.
- Completion: the capture that makes bit_count reach WIDTH completes the word. In that edge the word is handed to the output buffer, bit_count clears to 0, and the state returns to IDLE.
- data_valid rises on the edge after the final bit is sampled (1-cycle latency from last bit_valid).
- frame_start=1 while in SHIFT: abort the partial word without output and restart as in IDLE. The new dir is latched; the same-cycle bit_valid is captured as bit 1.
- Output buffer rules:
  - Transfer on data_valid & data_ready; data_valid drops next edge unless a new word loads that same edge.
  - Word completes while buffer empty, or full and consumed the same cycle: load, data_valid=1, no overrun.
  - Word completes while buffer full and not consumed: new word discarded, data_out unchanged, overrun<=1.
  - data_out and data_valid are not changed by frame_start or aborts.
- overrun: sticky; clear_overrun=1 clears it. If clear and a new overrun event occur in the same cycle, the set wins.
- bit_valid gaps of any length are allowed; there is no timeout.
- Async reset mid-frame discards the partial word and any buffered word.

Decomposition:
- Package usr_pkg:
  - state enum (ST_IDLE, ST_SHIFT).
  - direction constants DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1, shared with the transmit side.
- Sub-module usr_rx_shifter: WIDTH-bit bidirectional shift register with load-enable, dir, clear.
- Top module holds the FSM, bit counter, output buffer and overrun logic.

Test Plan:
- Reset: hold reset=0 while driving strobes, then release -> data_out=4'b0000, data_valid=0, busy=0, overrun=0 throughout.
- MSB first: frame_start+bit_valid with bits 1,0,1,0 on consecutive cycles, dir=0 -> data_valid=1 one edge after the 4th bit, data_out=4'b1010, busy falls on the same edge.
- LSB first with gaps: dir=1, bits 1,1,0,0 with 2-cycle idle gaps between strobes -> data_out=4'b0011, bit_count steps 1,2,3 then 0.
- Abort: 2 bits 1,1, then frame_start with bits 0,1,1,0 (dir=0) -> only one word, data_out=4'b0110.
- Backpressure: data_ready=0, send 4'b1010 then 4'b1100 -> data_out stays 4'b1010, overrun=1. Then data_ready=1 and clear_overrun=1 -> data_valid=0, overrun=0.
- Simultaneous consume: buffer holds 4'b1010, data_ready=1 on the final-bit cycle of 4'b1100 -> next edge data_out=4'b1100, data_valid=1, overrun=0.
